pc_fetch_ctrl: RTL and testbench

//  Drives the fetch side of the next-PC select mux. Holds the architectural PC
//  and issues one instruction-memory request at a time over a valid/ready handshake.

---
 rtl/pc_fetch_ctrl_if.sv | 27 ++
 rtl/pc_fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory port of the fetch controller: one request channel and
// one in-order response channel.
interface pc_fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: holds the architectural PC, issues one instruction fetch at a
// time, hands the fetched word to decode, and applies branch/jump redirects.
module pc_fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              stall,
    pc_fetch_ctrl_if.master   imem,
    output logic              inst_valid,
    output logic [XLEN-1:0]   inst_pc,
    output logic [XLEN-1:0]   inst_data,
    output logic [XLEN-1:0]   pc_plus4,
    output logic [1:0]        dbg_state
);
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    logic            iv_q, iv_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [XLEN-1:0] idata_q, idata_d;

    // Handshake: a request transfers on the cycle imem_req_valid && imem_req_ready
    // are both high; an unaccepted request may change address. A response is a
    // single-cycle imem_rsp_valid pulse with no back-pressure, strictly in order.
    assign imem.imem_req_valid = (state_q == S_REQ);
    assign imem.imem_req_addr  = pc_q;
    assign pc_plus4            = pc_q + STEP;
    assign inst_valid          = iv_q;
    assign inst_pc             = ipc_q;
    assign inst_data           = idata_q;
    assign dbg_state           = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            iv_q     <= 1'b0;
            ipc_q    <= '0;
            idata_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            iv_q     <= iv_d;
            ipc_q    <= ipc_d;
            idata_q  <= idata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        iv_d     = iv_q;
        ipc_d    = ipc_q;
        idata_d  = idata_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) pc_d = redirect_pc;
            end
            S_REQ: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (imem.imem_req_ready) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                    // Accepted fetch is already stale: mark its response for discard.
                    if (redirect_valid) drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                        if (redirect_valid) pc_d = redirect_pc;
                    end else begin
                        idata_d = imem.imem_rsp_data;
                        ipc_d   = req_pc_q;
                        iv_d    = 1'b1;
                        pc_d    = req_pc_q + STEP;
                        state_d = S_OUT;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                    pc_d   = redirect_pc;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    iv_d    = 1'b0;
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (!stall) begin
                    iv_d    = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a per-cycle vector table for the sequential
// fetch/backpressure/stall flow plus hand-written redirect and reset sequences.
module tb_pc_fetch_ctrl;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic        clk;
    logic        rst;
    logic        rdv;
    logic [31:0] rpc;
    logic        stall;
    logic        rdy;
    logic        rsv;
    logic [31:0] rdata;

    logic        iv_a, iv_b;
    logic [31:0] ipc_a, ipc_b, idata_a, idata_b, p4_a, p4_b;
    logic [1:0]  st_a, st_b;

    int checks = 0;
    int errors = 0;

    pc_fetch_ctrl_if #(.XLEN(32)) if_a ();
    pc_fetch_ctrl_if #(.XLEN(32)) if_b ();

    assign if_a.imem_req_ready = rdy;
    assign if_a.imem_rsp_valid = rsv;
    assign if_a.imem_rsp_data  = rdata;
    assign if_b.imem_req_ready = rdy;
    assign if_b.imem_rsp_valid = rsv;
    assign if_b.imem_rsp_data  = rdata;

    pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut_a (
        .clk(clk), .rst(rst), .redirect_valid(rdv), .redirect_pc(rpc), .stall(stall),
        .imem(if_a.master), .inst_valid(iv_a), .inst_pc(ipc_a), .inst_data(idata_a),
        .pc_plus4(p4_a), .dbg_state(st_a)
    );

    pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_b (
        .clk(clk), .rst(rst), .redirect_valid(rdv), .redirect_pc(rpc), .stall(stall),
        .imem(if_b.master), .inst_valid(iv_b), .inst_pc(ipc_b), .inst_data(idata_b),
        .pc_plus4(p4_b), .dbg_state(st_b)
    );

    // Clock / reset drive
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdv;
        logic [31:0] rpc;
        logic        stall;
        logic        rdy;
        logic        rsv;
        logic [31:0] rdata;
        logic        chk;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_idata;
        logic [31:0] e_p4;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] dw(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic a_rst, input logic a_rdv, input logic [31:0] a_rpc,
                       input logic a_stall, input logic a_rdy, input logic a_rsv,
                       input logic [31:0] a_rdata, input logic a_chk, input logic a_rqv,
                       input logic [31:0] a_addr, input logic a_iv, input logic [31:0] a_ipc,
                       input logic [31:0] a_idata, input logic [31:0] a_p4);
        vec_t v;
        v.rst = a_rst; v.rdv = a_rdv; v.rpc = a_rpc; v.stall = a_stall;
        v.rdy = a_rdy; v.rsv = a_rsv; v.rdata = a_rdata; v.chk = a_chk;
        v.e_rqv = a_rqv; v.e_addr = a_addr; v.e_iv = a_iv; v.e_ipc = a_ipc;
        v.e_idata = a_idata; v.e_p4 = a_p4;
        vecs.push_back(v);
    endtask

    // Driver: apply one cycle of inputs, advance past the edge, then idle the inputs.
    task automatic cyc(input logic c_rst, input logic c_rdv, input logic [31:0] c_rpc,
                       input logic c_stall, input logic c_rdy, input logic c_rsv,
                       input logic [31:0] c_rdata);
        rst = c_rst; rdv = c_rdv; rpc = c_rpc; stall = c_stall;
        rdy = c_rdy; rsv = c_rsv; rdata = c_rdata;
        @(posedge clk);
        #1;
        rst = 1'b0; rdv = 1'b0; rpc = '0; stall = 1'b0;
        rdy = 1'b0; rsv = 1'b0; rdata = '0;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    // From REQ at address a: accept, respond next cycle, check the instruction, leave OUT.
    task automatic fetch_one(input string tag, input logic [31:0] a);
        check({tag, " req_valid"}, {31'd0, if_a.imem_req_valid}, 32'd1);
        check({tag, " req_addr"}, if_a.imem_req_addr, a);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, dw(a));
        check({tag, " inst_valid"}, {31'd0, iv_a}, 32'd1);
        check({tag, " inst_pc"}, ipc_a, a);
        check({tag, " inst_data"}, idata_a, dw(a));
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; rdv = 1'b0; rpc = '0; stall = 1'b0;
        rdy = 1'b0; rsv = 1'b0; rdata = '0;

        // Sequential fetch 0,4,8 with one-cycle memory latency
        add(1,0,0,0,0,0,0,         0, 0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,         0, 0,0,0,0,0,0);
        add(0,0,0,0,1,0,0,         1, 0,32'h0,0,0,0,32'h4);
        add(0,0,0,0,1,0,0,         1, 1,32'h0,0,0,0,32'h4);
        add(0,0,0,0,0,1,dw(0),     1, 0,32'h0,0,0,0,32'h4);
        add(0,0,0,0,1,0,0,         1, 0,32'h4,1,32'h0,dw(0),32'h8);
        add(0,0,0,0,1,0,0,         1, 1,32'h4,0,32'h0,dw(0),32'h8);
        add(0,0,0,0,0,1,dw(4),     1, 0,32'h4,0,32'h0,dw(0),32'h8);
        add(0,0,0,0,1,0,0,         1, 0,32'h8,1,32'h4,dw(4),32'hC);
        add(0,0,0,0,1,0,0,         1, 1,32'h8,0,32'h4,dw(4),32'hC);
        add(0,0,0,0,0,1,dw(8),     1, 0,32'h8,0,32'h4,dw(4),32'hC);
        // Stall held in OUT for 4 cycles with memory ready: no new request
        for (int i = 0; i < 4; i++)
            add(0,0,0,1,1,0,0,     1, 0,32'hC,1,32'h8,dw(8),32'h10);
        add(0,0,0,0,0,0,0,         1, 0,32'hC,1,32'h8,dw(8),32'h10);
        add(0,0,0,0,0,0,0,         1, 1,32'hC,0,32'h8,dw(8),32'h10);
        // Fresh reset, then memory not ready for 5 cycles and 2-cycle latency
        add(1,0,0,0,0,0,0,         0, 0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,         0, 0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,         1, 0,32'h0,0,0,0,32'h4);
        for (int i = 0; i < 5; i++)
            add(0,0,0,0,0,0,0,     1, 1,32'h0,0,0,0,32'h4);
        add(0,0,0,0,1,0,0,         1, 1,32'h0,0,0,0,32'h4);
        add(0,0,0,0,0,0,0,         1, 0,32'h0,0,0,0,32'h4);
        add(0,0,0,0,0,1,dw(0),     1, 0,32'h0,0,0,0,32'h4);
        add(0,0,0,0,0,0,0,         1, 0,32'h4,1,32'h0,dw(0),32'h8);
        add(0,0,0,0,0,0,0,         1, 1,32'h4,0,32'h0,dw(0),32'h8);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; rdv = vecs[i].rdv; rpc = vecs[i].rpc;
            stall = vecs[i].stall; rdy = vecs[i].rdy; rsv = vecs[i].rsv;
            rdata = vecs[i].rdata;
            if (vecs[i].chk) begin
                check($sformatf("row%0d req_valid", i), {31'd0, if_a.imem_req_valid}, {31'd0, vecs[i].e_rqv});
                check($sformatf("row%0d req_addr", i), if_a.imem_req_addr, vecs[i].e_addr);
                check($sformatf("row%0d inst_valid", i), {31'd0, iv_a}, {31'd0, vecs[i].e_iv});
                check($sformatf("row%0d inst_pc", i), ipc_a, vecs[i].e_ipc);
                check($sformatf("row%0d inst_data", i), idata_a, vecs[i].e_idata);
                check($sformatf("row%0d pc_plus4", i), p4_a, vecs[i].e_p4);
            end
            @(posedge clk);
            #1;
        end

        // Redirect to 0x100 while the fetch of 0x8 is outstanding
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        fetch_one("t4_a", 32'h0);
        fetch_one("t4_b", 32'h4);
        check("t4 req_addr8", if_a.imem_req_addr, 32'h8);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 32'h100, 0, 0, 0, 0);
        check("t4 state_wait", {30'd0, st_a}, {30'd0, ST_WAIT});
        check("t4 no_req_in_wait", {31'd0, if_a.imem_req_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1, dw(32'h8));
        check("t4 stale_dropped", {31'd0, iv_a}, 32'd0);
        fetch_one("t4_c", 32'h100);

        // Redirect in the same cycle the fetch of 0x4 is accepted
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        fetch_one("t5_a", 32'h0);
        check("t5 req_addr4", if_a.imem_req_addr, 32'h4);
        cyc(0, 1, 32'h40, 0, 1, 0, 0);
        check("t5 state_wait", {30'd0, st_a}, {30'd0, ST_WAIT});
        cyc(0, 0, 0, 0, 0, 1, dw(32'h4));
        check("t5 stale_dropped", {31'd0, iv_a}, 32'd0);
        check("t5 state_req", {30'd0, st_a}, {30'd0, ST_REQ});
        fetch_one("t5_b", 32'h40);
        // Redirect beats stall in OUT; redirect of an unaccepted request
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, dw(32'h44));
        check("t5 out_valid", {31'd0, iv_a}, 32'd1);
        cyc(0, 1, 32'h200, 1, 0, 0, 0);
        check("t5 out_redirect_iv", {31'd0, iv_a}, 32'd0);
        check("t5 out_redirect_addr", if_a.imem_req_addr, 32'h200);
        cyc(0, 1, 32'h300, 0, 0, 0, 0);
        check("t5 req_redirect_state", {30'd0, st_a}, {30'd0, ST_REQ});
        fetch_one("t5_c", 32'h300);

        // Wrapping reset PC, then reset during WAIT with a late response
        do_reset();
        check("t6 rst_addr", if_b.imem_req_addr, 32'hFFFF_FFFC);
        check("t6 rst_pc_plus4", p4_b, 32'h0);
        check("t6 rst_req_valid", {31'd0, if_b.imem_req_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("t6 req_addr_top", if_b.imem_req_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, dw(32'hFFFF_FFFC));
        check("t6 inst_pc_top", ipc_b, 32'hFFFF_FFFC);
        check("t6 inst_data_top", idata_b, dw(32'hFFFF_FFFC));
        check("t6 wrapped_pc", if_b.imem_req_addr, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("t6 wrapped_req_valid", {31'd0, if_b.imem_req_valid}, 32'd1);
        check("t6 wrapped_req_addr", if_b.imem_req_addr, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("t6 state_wait", {30'd0, st_b}, {30'd0, ST_WAIT});
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t6 rst_in_wait_state", {30'd0, st_b}, {30'd0, ST_IDLE});
        check("t6 rst_in_wait_inst_valid", {31'd0, iv_b}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("t6 late_rsp_iv", {31'd0, iv_b}, 32'd0);
        check("t6 late_rsp_data", idata_b, 32'h0);
        check("t6 late_rsp_state", {30'd0, st_b}, {30'd0, ST_REQ});
        cyc(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("t6 rsp_in_req_state", {30'd0, st_b}, {30'd0, ST_REQ});
        check("t6 rsp_in_req_iv", {31'd0, iv_b}, 32'd0);
        check("t6 rsp_in_req_addr", if_b.imem_req_addr, 32'hFFFF_FFFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
